// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared types and constants for the hazard controller
// Contents: FSM state encoding (ST_RUN, ST_FLUSH), register address width, x0 address.
package hazard_ctrl_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

endpackage

// File: rtl/hz_scoreboard.sv
// rtl/hz_scoreboard.sv - per-register pending-writer scoreboard, two read ports
// Ports:
//   clk, rst             core clock, synchronous active-high reset
//   set_en, set_addr     mark a register as awaiting a long-latency writeback
//   clr_en, clr_addr     writeback completed for a register
//   rd_addr_a/b          read port addresses (ID rs1 / rs2)
//   rd_busy_a/b          register has a pending writer
module hz_scoreboard
    import hazard_ctrl_pkg::*;
#(
    parameter int NREG = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_addr,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_addr,
    input  logic [REG_ADDR_W-1:0] rd_addr_a,
    input  logic [REG_ADDR_W-1:0] rd_addr_b,
    output logic                  rd_busy_a,
    output logic                  rd_busy_b
);

    logic [NREG-1:0] sb_q;
    logic [NREG-1:0] sb_d;

    // Clear is applied first so a same-cycle set of the same register wins.
    // x0 is never set, so reads of x0 never report busy.
    always_comb begin
        sb_d = sb_q;
        if (clr_en && (clr_addr != ZERO_REG)) begin
            sb_d[clr_addr] = 1'b0;
        end
        if (set_en && (set_addr != ZERO_REG)) begin
            sb_d[set_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    // Reads see the registered vector: a clear only becomes visible after the edge.
    assign rd_busy_a = sb_q[rd_addr_a];
    assign rd_busy_b = sb_q[rd_addr_b];

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - IF/ID/EX pipeline hold, flush and redirect sequencing
// Ports:
//   clk, rst                 core clock, synchronous active-high reset
//   id_*                     decode-stage instruction operands and write intent
//   ex_busy_i                EX multi-cycle op still running
//   ex_jump_en_i/addr_i      EX resolved a taken jump/branch and its target
//   wb_clr_i/addr_i          long-latency result written back
//   hold_*_o, flush_*_o      freeze / bubble controls for PC, if_id, id_ex
//   jump_en_o, jump_addr_o   PC redirect
//   id_fire_o                ID instruction advances into EX
//   stall_cnt_o, flush_cnt_o performance counters, present only with HAZARD_PERF_EN
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int NREG         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
    input  logic                  id_rs1_ren_i,
    input  logic                  id_rs2_ren_i,
    input  logic [REG_ADDR_W-1:0] id_rd_addr_i,
    input  logic                  id_reg_wen_i,
    input  logic                  id_long_i,
    input  logic                  ex_busy_i,
    input  logic                  ex_jump_en_i,
    input  logic [31:0]           ex_jump_addr_i,
    input  logic                  wb_clr_i,
    input  logic [REG_ADDR_W-1:0] wb_clr_addr_i,
    output logic                  hold_pc_o,
    output logic                  hold_if_id_o,
    output logic                  hold_id_ex_o,
    output logic                  flush_if_id_o,
    output logic                  flush_id_ex_o,
    output logic                  jump_en_o,
    output logic [31:0]           jump_addr_o,
`ifdef HAZARD_PERF_EN
    output logic [31:0]           stall_cnt_o,
    output logic [31:0]           flush_cnt_o,
`endif
    output logic                  id_fire_o
);

    // The jump cycle itself is the first flush cycle, so FLUSH holds for FLUSH_CYCLES-1 more.
    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       rs1_busy, rs2_busy, hazard, sb_set;

    assign sb_set = id_fire_o & id_reg_wen_i & id_long_i;
    assign hazard = id_valid_i & ((id_rs1_ren_i & rs1_busy) | (id_rs2_ren_i & rs2_busy));

    hz_scoreboard #(.NREG(NREG)) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .set_en    (sb_set),
        .set_addr  (id_rd_addr_i),
        .clr_en    (wb_clr_i),
        .clr_addr  (wb_clr_addr_i),
        .rd_addr_a (id_rs1_addr_i),
        .rd_addr_b (id_rs2_addr_i),
        .rd_busy_a (rs1_busy),
        .rd_busy_b (rs2_busy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Priority: jump > FLUSH > ex_busy > scoreboard hazard > normal issue.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        hold_pc_o     = 1'b0;
        hold_if_id_o  = 1'b0;
        hold_id_ex_o  = 1'b0;
        flush_if_id_o = 1'b0;
        flush_id_ex_o = 1'b0;
        jump_en_o     = 1'b0;
        jump_addr_o   = '0;
        id_fire_o     = 1'b0;
        if (rst) begin
            // all outputs stay low while in reset
        end else if (ex_jump_en_i) begin
            jump_en_o     = 1'b1;
            jump_addr_o   = ex_jump_addr_i;
            flush_if_id_o = 1'b1;
            flush_id_ex_o = 1'b1;
            state_d       = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
            cnt_d         = FLUSH_INIT;
        end else if (state_q == ST_FLUSH) begin
            flush_if_id_o = 1'b1;
            flush_id_ex_o = 1'b1;
            if (cnt_q <= 3'd1) begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q - 3'd1;
            end
        end else if (ex_busy_i) begin
            hold_pc_o    = 1'b1;
            hold_if_id_o = 1'b1;
            hold_id_ex_o = 1'b1;
        end else if (hazard) begin
            // Keep the consumer in ID and feed a bubble into EX.
            hold_pc_o     = 1'b1;
            hold_if_id_o  = 1'b1;
            flush_id_ex_o = 1'b1;
        end else begin
            id_fire_o = id_valid_i;
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (hold_pc_o) begin
                stall_cnt_o <= stall_cnt_o + 32'd1;
            end
            if (ex_jump_en_i) begin
                flush_cnt_o <= flush_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid_i;
    logic [4:0]  id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i, wb_clr_addr_i;
    logic        id_rs1_ren_i, id_rs2_ren_i, id_reg_wen_i, id_long_i;
    logic        ex_busy_i, ex_jump_en_i, wb_clr_i;
    logic [31:0] ex_jump_addr_i;
    logic        hold_pc_o, hold_if_id_o, hold_id_ex_o;
    logic        flush_if_id_o, flush_id_ex_o, jump_en_o, id_fire_o;
    logic [31:0] jump_addr_o;

    int checks   = 0;
    int failures = 0;

    // Reference state: pending-writer set and remaining flush-only cycles.
    logic [31:0] m_sb  = '0;
    int          m_rem = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.NREG(32), .FLUSH_CYCLES(FC)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid_i     (id_valid_i),
        .id_rs1_addr_i  (id_rs1_addr_i),
        .id_rs2_addr_i  (id_rs2_addr_i),
        .id_rs1_ren_i   (id_rs1_ren_i),
        .id_rs2_ren_i   (id_rs2_ren_i),
        .id_rd_addr_i   (id_rd_addr_i),
        .id_reg_wen_i   (id_reg_wen_i),
        .id_long_i      (id_long_i),
        .ex_busy_i      (ex_busy_i),
        .ex_jump_en_i   (ex_jump_en_i),
        .ex_jump_addr_i (ex_jump_addr_i),
        .wb_clr_i       (wb_clr_i),
        .wb_clr_addr_i  (wb_clr_addr_i),
        .hold_pc_o      (hold_pc_o),
        .hold_if_id_o   (hold_if_id_o),
        .hold_id_ex_o   (hold_id_ex_o),
        .flush_if_id_o  (flush_if_id_o),
        .flush_id_ex_o  (flush_id_ex_o),
        .jump_en_o      (jump_en_o),
        .jump_addr_o    (jump_addr_o),
        .id_fire_o      (id_fire_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b0; id_valid_i = 1'b0; id_rs1_addr_i = '0; id_rs2_addr_i = '0;
        id_rs1_ren_i = 1'b0; id_rs2_ren_i = 1'b0; id_rd_addr_i = '0; id_reg_wen_i = 1'b0;
        id_long_i = 1'b0; ex_busy_i = 1'b0; ex_jump_en_i = 1'b0; ex_jump_addr_i = '0;
        wb_clr_i = 1'b0; wb_clr_addr_i = '0;
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rs1, input logic r1,
                            input logic [4:0] rs2, input logic r2,
                            input logic [4:0] rd, input logic wen, input logic lng);
        id_valid_i = v; id_rs1_addr_i = rs1; id_rs1_ren_i = r1;
        id_rs2_addr_i = rs2; id_rs2_ren_i = r2;
        id_rd_addr_i = rd; id_reg_wen_i = wen; id_long_i = lng;
    endtask

    // Check every output against the reference, then advance one clock and update it.
    task automatic cyc(input string tag);
        logic [6:0]  ev;  // {hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex, jump_en, fire}
        logic [31:0] ea;
        logic        stall;
        #1;
        ev = '0;
        ea = '0;
        stall = id_valid_i && ((id_rs1_ren_i && m_sb[id_rs1_addr_i]) ||
                               (id_rs2_ren_i && m_sb[id_rs2_addr_i]));
        if (rst) begin
            ev = '0;
        end else if (ex_jump_en_i) begin
            ev = 7'b0001110;
            ea = ex_jump_addr_i;
        end else if (m_rem > 0) begin
            ev = 7'b0001100;
        end else if (ex_busy_i) begin
            ev = 7'b1110000;
        end else if (stall) begin
            ev = 7'b1100100;
        end else begin
            ev = {6'b0, id_valid_i};
        end
        chk({tag, "/ctl"}, {25'b0, hold_pc_o, hold_if_id_o, hold_id_ex_o, flush_if_id_o,
                            flush_id_ex_o, jump_en_o, id_fire_o}, {25'b0, ev});
        chk({tag, "/addr"}, jump_addr_o, ea);
        @(posedge clk);
        if (rst) begin
            m_sb  = '0;
            m_rem = 0;
        end else begin
            if (wb_clr_i && wb_clr_addr_i != 5'd0) m_sb[wb_clr_addr_i] = 1'b0;
            if (ev[0] && id_reg_wen_i && id_long_i && id_rd_addr_i != 5'd0) m_sb[id_rd_addr_i] = 1'b1;
            if (ex_jump_en_i) m_rem = FC - 1;
            else if (m_rem > 0) m_rem = m_rem - 1;
        end
        #1;
    endtask

    initial begin
        // Reset: outputs forced low even with a jump and a valid ID presented.
        idle();
        rst = 1'b1; ex_jump_en_i = 1'b1; ex_jump_addr_i = 32'h1234_5678; id_valid_i = 1'b1;
        #1 chk("rst_jump", {31'b0, jump_en_o}, 32'd0);
        chk("rst_fire", {31'b0, id_fire_o}, 32'd0);
        cyc("rst0");
        cyc("rst1");

        // Load-use: long load to x5, consumer stalls through the writeback cycle.
        idle();
        drive_id(1, 0, 0, 0, 0, 5'd5, 1, 1);
        #1 chk("ld_fire", {31'b0, id_fire_o}, 32'd1);
        cyc("ld");
        drive_id(1, 5'd5, 1, 0, 0, 5'd6, 1, 0);
        for (int i = 0; i < 3; i++) begin
            #1 chk("lu_hold_pc", {31'b0, hold_pc_o}, 32'd1);
            chk("lu_bubble", {31'b0, flush_id_ex_o}, 32'd1);
            cyc("lu_stall");
        end
        wb_clr_i = 1'b1; wb_clr_addr_i = 5'd5;
        #1 chk("lu_wb_cycle", {31'b0, hold_pc_o}, 32'd1);
        cyc("lu_wb");
        wb_clr_i = 1'b0;
        #1 chk("lu_fire", {31'b0, id_fire_o}, 32'd1);
        cyc("lu_go");

        // Jump: redirect plus exactly FC flush cycles, no issue.
        idle();
        id_valid_i = 1'b1;
        ex_jump_en_i = 1'b1; ex_jump_addr_i = 32'h8000_0010;
        #1 chk("jmp_en", {31'b0, jump_en_o}, 32'd1);
        chk("jmp_addr", jump_addr_o, 32'h8000_0010);
        chk("jmp_fire", {31'b0, id_fire_o}, 32'd0);
        cyc("jmp");
        ex_jump_en_i = 1'b0;
        #1 chk("fl1_flush", {30'b0, flush_if_id_o, flush_id_ex_o}, 32'd3);
        chk("fl1_fire", {31'b0, id_fire_o}, 32'd0);
        cyc("fl1");
        #1 chk("fl_done", {30'b0, flush_if_id_o, id_fire_o}, 32'd1);
        cyc("fl_done");

        // ex_busy dominates a pending hazard, then the hazard stall takes over.
        idle();
        drive_id(1, 0, 0, 0, 0, 5'd9, 1, 1);
        cyc("busy_ld");
        drive_id(1, 0, 0, 5'd9, 1, 5'd1, 1, 0);
        ex_busy_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1 chk("busy_holds", {29'b0, hold_pc_o, hold_if_id_o, hold_id_ex_o}, 32'd7);
            chk("busy_noflush", {31'b0, flush_id_ex_o}, 32'd0);
            cyc("busy");
        end
        ex_busy_i = 1'b0;
        #1 chk("post_busy", {29'b0, hold_pc_o, hold_id_ex_o, flush_id_ex_o}, 32'd5);
        cyc("post_busy");
        wb_clr_i = 1'b1; wb_clr_addr_i = 5'd9;
        cyc("busy_wb");

        // x0 destination never tracked.
        idle();
        drive_id(1, 0, 0, 0, 0, 5'd0, 1, 1);
        cyc("x0_ld");
        drive_id(1, 5'd0, 1, 5'd0, 1, 5'd2, 1, 0);
        #1 chk("x0_fire", {31'b0, id_fire_o}, 32'd1);
        cyc("x0_use");

        // Same-cycle set and clear of x7: set wins.
        idle();
        drive_id(1, 0, 0, 0, 0, 5'd7, 1, 1);
        wb_clr_i = 1'b1; wb_clr_addr_i = 5'd7;
        cyc("sc_both");
        idle();
        drive_id(1, 5'd7, 1, 0, 0, 5'd2, 0, 0);
        #1 chk("sc_stall", {31'b0, hold_pc_o}, 32'd1);
        cyc("sc_use");
        idle();
        wb_clr_i = 1'b1; wb_clr_addr_i = 5'd7;
        cyc("sc_clr");

        // Reset in the middle of FLUSH clears state and scoreboard.
        idle();
        drive_id(1, 0, 0, 0, 0, 5'd3, 1, 1);
        cyc("rf_ld");
        idle();
        ex_jump_en_i = 1'b1; ex_jump_addr_i = 32'h0000_0100;
        cyc("rf_jmp");
        idle();
        rst = 1'b1; id_valid_i = 1'b1;
        #1 chk("rf_all0", {24'b0, hold_pc_o, hold_if_id_o, hold_id_ex_o, flush_if_id_o,
                           flush_id_ex_o, jump_en_o, id_fire_o, 1'b0} | jump_addr_o, 32'd0);
        cyc("rf_rst");
        idle();
        drive_id(1, 5'd3, 1, 0, 0, 5'd4, 1, 0);
        #1 chk("rf_fire", {31'b0, id_fire_o}, 32'd1);
        cyc("rf_go");

        // Randomized traffic against the reference model.
        for (int n = 0; n < 1500; n++) begin
            rst            = ($urandom_range(99) == 0);
            ex_jump_en_i   = ($urandom_range(19) == 0);
            ex_jump_addr_i = $urandom;
            ex_busy_i      = ($urandom_range(7) == 0);
            wb_clr_i       = ($urandom_range(2) == 0);
            wb_clr_addr_i  = 5'($urandom_range(7));
            drive_id(1'($urandom_range(3) != 0),
                     5'($urandom_range(7)), 1'($urandom_range(1)),
                     5'($urandom_range(7)), 1'($urandom_range(1)),
                     5'($urandom_range(7)), 1'($urandom_range(1)), 1'($urandom_range(1)));
            cyc("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the IF / ID / EX core; sits beside the decode stage and drives hold/flush of the PC and the if_id and id_ex registers.
- Tracks in-flight long-latency writers (loads, multi-cycle ops) in a per-register scoreboard and stalls decode on RAW hazards.
- Freezes upstream stages while EX is busy, and sequences a multi-cycle flush plus redirect on EX-resolved jumps and branches.

Parameters:
- NREG, 32, number of architectural registers; the scoreboard width.
- FLUSH_CYCLES, 2, cycles that flush_if_id_o/flush_id_ex_o stay asserted after a jump (1..7).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- id_valid_i  in  1  ID holds a valid instruction
- id_rs1_addr_i  in  5  ID source 1 address
- id_rs2_addr_i  in  5  ID source 2 address
- id_rs1_ren_i  in  1  ID reads rs1
- id_rs2_ren_i  in  1  ID reads rs2
- id_rd_addr_i  in  5  ID destination
- id_reg_wen_i  in  1  ID writes rd
- id_long_i  in  1  ID instruction is long-latency (result via wb_clr)
- ex_busy_i  in  1  EX multi-cycle op not finished
- ex_jump_en_i  in  1  EX resolved a taken jump/branch
- ex_jump_addr_i  in  32  redirect target
- wb_clr_i  in  1  long-latency result written back
- wb_clr_addr_i  in  5  register written back
- hold_pc_o  out  1  freeze PC
- hold_if_id_o  out  1  freeze if_id
- hold_id_ex_o  out  1  freeze id_ex
- flush_if_id_o  out  1  zero if_id (bubble)
- flush_id_ex_o  out  1  zero id_ex (bubble)
- jump_en_o  out  1  redirect PC
- jump_addr_o  out  32  redirect target
- id_fire_o  out  1  ID instruction advances into EX this cycle

Behaviour:
- State: FSM {RUN, FLUSH}, flush counter, sb[NREG-1:0]. Reset (clk edge with rst=1): state=RUN, counter=0, sb=0.
- While rst=1, every output is forced to 0.
- Outputs are combinational from current state and inputs; the FSM, counter and sb update on the clk edge.
- Priority per cycle: jump > FLUSH state > ex_busy > scoreboard hazard.
- Jump (ex_jump_en_i=1, any state):
  - jump_en_o=1 and jump_addr_o=ex_jump_addr_i the same cycle.
  - flush_if_id_o=flush_id_ex_o=1; all hold_* outputs 0.
  - Next state FLUSH, counter=FLUSH_CYCLES-1. A jump arriving during FLUSH restarts the counter.
- FLUSH: flush_if_id_o=flush_id_ex_o=1 and id_fire_o=0. Counter decrements each cycle; RUN when counter==0 at the edge. If FLUSH_CYCLES=1, return to RUN directly.
- ex_busy (RUN, no jump): hold_pc_o=hold_if_id_o=hold_id_ex_o=1, flushes 0, id_fire_o=0.
- Hazard (RUN, no jump, no busy): hazard = id_valid_i & ((id_rs1_ren_i & sb[rs1]) | (id_rs2_ren_i & sb[rs2])).
  - Action: hold_pc_o=hold_if_id_o=1, flush_id_ex_o=1 (bubble), id_fire_o=0.
- Otherwise: id_fire_o=id_valid_i.
- Scoreboard set when id_fire_o & id_reg_wen_i & id_long_i & rd!=0. Scoreboard clear when wb_clr_i & wb_clr_addr!=0.
- Same-cycle set and clear of the same register: set wins.
- A clear is visible the cycle after the edge; a consumer stalls through the writeback cycle.
- Register 0 is never set, so reads of x0 never stall.
- A fired instruction is never flushed later by this block; in-flight sb bits persist across flushes.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined: adds output ports stall_cnt_o[31:0] (cycles with hold_pc_o=1) and flush_cnt_o[31:0] (count of ex_jump_en_i pulses). Both zero on rst and wrap at 2^32.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared defines: FSM state encodings (ST_RUN, ST_FLUSH), REG_ADDR_W=5, ZERO_REG.
- One sub-module is natural: hz_scoreboard (set/clear/read of the sb vector, two read ports). FSM and output logic stay in hazard_ctrl.

Test Plan:
- Load, rd=5, id_long_i=1 fires; next ID rs1=5 rs1_ren=1 → hold_pc_o=hold_if_id_o=flush_id_ex_o=1 each cycle until the cycle after wb_clr_i with addr 5; then id_fire_o=1.
- ex_jump_en_i=1, addr 0x8000_0010 → jump_en_o=1, jump_addr_o=0x8000_0010; flush_if_id_o=flush_id_ex_o=1 for exactly 2 cycles; id_fire_o=0 throughout.
- ex_busy_i high 5 cycles with a hazard pending → hold_pc/if_id/id_ex=1 for 5 cycles, flush_id_ex_o=0; then scoreboard stall applies.
- Long op with rd=0, then consumer rs1=0 → sb stays 0, no stall.
- Same cycle: fire long rd=7 and wb_clr addr 7 → sb[7]=1 afterwards; a consumer of x7 stalls.
- rst asserted during FLUSH counter=1 → all outputs 0; state RUN, sb=0 after the edge; a new ID fires normally.
